// File: rtl/ctrl_pkg.sv
// Shared definitions for the multicycle ARM-subset controller:
// FSM states, ALU control codes, opcode/condition/command encodings.
package ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_ORR = 3'b011;
  localparam logic [2:0] ALU_EOR = 3'b100;
  localparam logic [2:0] ALU_MOV = 3'b101;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_EOR = 4'b0001;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_CMN = 4'b1011;
  localparam logic [3:0] CMD_ORR = 4'b1100;
  localparam logic [3:0] CMD_MOV = 4'b1101;

endpackage

// File: rtl/cond_unit.sv
// NZCV flag register with per-group write mask, plus condition evaluation
// of the instruction's cond field against the registered flags.
module cond_unit
  import ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] cond,
  input  logic [3:0] alu_flags,
  input  logic [1:0] flag_w,     // [1] writes N/Z, [0] writes C/V
  input  logic       flag_en,
  output logic [3:0] flags,
  output logic       cond_ex
);

  logic n, z, c, v;
  assign {n, z, c, v} = flags;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flags <= 4'b0000;
    end else if (flag_en) begin
      if (flag_w[1]) flags[3:2] <= alu_flags[3:2];
      if (flag_w[0]) flags[1:0] <= alu_flags[1:0];
    end
  end

  always_comb begin
    cond_ex = 1'b0;
    case (cond)
      COND_EQ: cond_ex = z;
      COND_NE: cond_ex = !z;
      COND_CS: cond_ex = c;
      COND_CC: cond_ex = !c;
      COND_MI: cond_ex = n;
      COND_PL: cond_ex = !n;
      COND_VS: cond_ex = v;
      COND_VC: cond_ex = !v;
      COND_HI: cond_ex = c && !z;
      COND_LS: cond_ex = !c || z;
      COND_GE: cond_ex = (n == v);
      COND_LT: cond_ex = (n != v);
      COND_GT: cond_ex = !z && (n == v);
      COND_LE: cond_ex = z || (n != v);
      COND_AL: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle control FSM and instruction decode for the ARM-subset core.
//   state  | meaning
//   FETCH  | read instruction, PC <= PC+4 on MemReady
//   DECODE | read registers, PC+8 on ALU, evaluate condition
//   MEMADR | compute load/store address (base +/- offset)
//   MEMRD  | load data read, wait for MemReady
//   MEMWB  | write loaded data to Rd
//   MEMWR  | store data write, wait for MemReady
//   EXECR  | data-processing with register operand
//   EXECI  | data-processing with immediate operand
//   ALUWB  | write ALU result to Rd
//   BRANCH | PC <= branch target
module multicycle_controller
  import ctrl_pkg::*;
#(
  parameter int ALUCTRL_W     = 3,
  parameter int MEM_HANDSHAKE = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [31:0]          Instr,
  input  logic [3:0]           ALUFlags,
  input  logic                 MemReady,
  output logic                 PCWrite,
  output logic                 IRWrite,
  output logic                 RegWrite,
  output logic                 MemWrite,
  output logic                 AdrSrc,
  output logic [1:0]           ResultSrc,
  output logic [1:0]           ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [1:0]           ImmSrc,
  output logic [1:0]           RegSrc,
  output logic [ALUCTRL_W-1:0] ALUControl,
  output logic [3:0]           Flags,
  output logic                 Illegal
);

  state_t      state, state_n;
  logic [3:0]  cond, cmd, rd;
  logic [1:0]  op;
  logic [5:0]  funct;
  logic        mem_rdy, cond_ex;
  logic [2:0]  dp_alu, alu_ctrl;
  logic        dp_ok, no_write, logic_op;
  logic [1:0]  flag_w;
  logic        pc_write, ir_write, reg_write, mem_write, flag_en, illegal;
  logic        unused_instr;

  assign cond  = Instr[31:28];
  assign op    = Instr[27:26];
  assign funct = Instr[25:20];
  assign rd    = Instr[15:12];
  assign cmd   = funct[4:1];
  assign unused_instr = ^{Instr[19:16], Instr[11:0]};

  assign mem_rdy = (MEM_HANDSHAKE != 0) ? MemReady : 1'b1;

  always_comb begin
    dp_alu   = ALU_ADD;
    dp_ok    = 1'b1;
    no_write = 1'b0;
    logic_op = 1'b0;
    flag_w   = 2'b00;
    case (cmd)
      CMD_ADD: dp_alu = ALU_ADD;
      CMD_SUB: dp_alu = ALU_SUB;
      CMD_AND: begin dp_alu = ALU_AND; logic_op = 1'b1; end
      CMD_ORR: begin dp_alu = ALU_ORR; logic_op = 1'b1; end
      CMD_EOR: begin dp_alu = ALU_EOR; logic_op = 1'b1; dp_ok = (ALUCTRL_W > 2); end
      CMD_MOV: begin dp_alu = ALU_MOV; logic_op = 1'b1; dp_ok = (ALUCTRL_W > 2); end
      CMD_CMP: begin dp_alu = ALU_SUB; no_write = 1'b1; end
      CMD_CMN: begin dp_alu = ALU_ADD; no_write = 1'b1; end
      default: dp_ok = 1'b0;
    endcase
    // logical ops leave C and V untouched
    if (funct[0] || no_write) flag_w = logic_op ? 2'b10 : 2'b11;
  end

  cond_unit u_cond (
    .clk       (clk),
    .rst_n     (rst_n),
    .cond      (cond),
    .alu_flags (ALUFlags),
    .flag_w    (flag_w),
    .flag_en   (flag_en),
    .flags     (Flags),
    .cond_ex   (cond_ex)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= FETCH;
    else        state <= state_n;
  end

  always_comb begin
    state_n   = state;
    pc_write  = 1'b0;
    ir_write  = 1'b0;
    reg_write = 1'b0;
    mem_write = 1'b0;
    flag_en   = 1'b0;
    illegal   = 1'b0;
    AdrSrc    = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    alu_ctrl  = ALU_ADD;
    case (state)
      FETCH: begin
        ALUSrcA = 2'b01; ALUSrcB = 2'b10; ResultSrc = 2'b10;
        if (mem_rdy) begin
          ir_write = 1'b1; pc_write = 1'b1; state_n = DECODE;
        end
      end
      DECODE: begin
        ALUSrcA = 2'b01; ALUSrcB = 2'b10;
        state_n = FETCH;
        // NV is undefined rather than never-executed
        if (cond == COND_NV) illegal = 1'b1;
        else if (cond_ex) begin
          case (op)
            OP_MEM:  state_n = MEMADR;
            OP_BR:   state_n = BRANCH;
            OP_DP:   if (!dp_ok) illegal = 1'b1;
                     else state_n = funct[5] ? EXECI : EXECR;
            default: illegal = 1'b1;
          endcase
        end
      end
      MEMADR: begin
        ALUSrcB  = 2'b01;
        alu_ctrl = funct[3] ? ALU_ADD : ALU_SUB;
        state_n  = funct[0] ? MEMRD : MEMWR;
      end
      MEMRD: begin
        AdrSrc = 1'b1;
        if (mem_rdy) state_n = MEMWB;
      end
      MEMWB: begin
        ResultSrc = 2'b01; reg_write = 1'b1; pc_write = (rd == 4'hF);
        state_n = FETCH;
      end
      MEMWR: begin
        AdrSrc = 1'b1; mem_write = 1'b1;
        if (mem_rdy) state_n = FETCH;
      end
      EXECR, EXECI: begin
        ALUSrcB  = (state == EXECI) ? 2'b01 : 2'b00;
        alu_ctrl = dp_alu;
        flag_en  = 1'b1;
        state_n  = no_write ? FETCH : ALUWB;
      end
      ALUWB: begin
        reg_write = 1'b1; pc_write = (rd == 4'hF);
        state_n = FETCH;
      end
      BRANCH: begin
        ALUSrcB = 2'b01; ResultSrc = 2'b10; pc_write = 1'b1;
        state_n = FETCH;
      end
      default: state_n = FETCH;
    endcase
  end

  always_comb begin
    ImmSrc = 2'b00;
    RegSrc = 2'b00;
    case (op)
      OP_MEM:  begin ImmSrc = 2'b01; RegSrc = funct[0] ? 2'b00 : 2'b10; end
      OP_BR:   begin ImmSrc = 2'b10; RegSrc = 2'b01; end
      default: begin ImmSrc = 2'b00; RegSrc = 2'b00; end
    endcase
  end

  assign ALUControl = alu_ctrl[ALUCTRL_W-1:0];

  // reset overrides every strobe, including the FETCH defaults
  assign PCWrite  = rst_n & pc_write;
  assign IRWrite  = rst_n & ir_write;
  assign RegWrite = rst_n & reg_write;
  assign MemWrite = rst_n & mem_write;
  assign Illegal  = rst_n & illegal;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: default build (a) and the
// 2-bit ALUControl build (b) share stimulus; each run is observed per cycle.
module tb_multicycle_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] Instr = 32'h0;
  logic [3:0]  ALUFlags = 4'h0;
  logic        MemReady = 1'b1;

  logic       pcw_a, irw_a, rw_a, mw_a, adr_a, ill_a;
  logic [1:0] rs_a, sa_a, sb_a, imm_a, reg_a;
  logic [2:0] alu_a;
  logic [3:0] fl_a;
  logic       pcw_b, irw_b, rw_b, mw_b, adr_b, ill_b;
  logic [1:0] rs_b, sa_b, sb_b, imm_b, reg_b;
  logic [1:0] alu_b;
  logic [3:0] fl_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  multicycle_controller #(.ALUCTRL_W(3), .MEM_HANDSHAKE(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .Instr(Instr), .ALUFlags(ALUFlags), .MemReady(MemReady),
    .PCWrite(pcw_a), .IRWrite(irw_a), .RegWrite(rw_a), .MemWrite(mw_a), .AdrSrc(adr_a),
    .ResultSrc(rs_a), .ALUSrcA(sa_a), .ALUSrcB(sb_a), .ImmSrc(imm_a), .RegSrc(reg_a),
    .ALUControl(alu_a), .Flags(fl_a), .Illegal(ill_a));

  multicycle_controller #(.ALUCTRL_W(2), .MEM_HANDSHAKE(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .Instr(Instr), .ALUFlags(ALUFlags), .MemReady(MemReady),
    .PCWrite(pcw_b), .IRWrite(irw_b), .RegWrite(rw_b), .MemWrite(mw_b), .AdrSrc(adr_b),
    .ResultSrc(rs_b), .ALUSrcA(sa_b), .ALUSrcB(sb_b), .ImmSrc(imm_b), .RegSrc(reg_b),
    .ALUControl(alu_b), .Flags(fl_b), .Illegal(ill_b));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one instruction from its FETCH until the next FETCH completes a read.
  // stall bit i drives MemReady=0 in cycle i of the instruction.
  task automatic run_instr(input string tag, input bit use_b, input logic [31:0] ins,
                           input logic [3:0] af, input logic [15:0] stall,
                           input int exp_cyc, input int exp_rw, input int exp_pcw,
                           input int exp_mw, input int exp_ill, input int exp_alu2,
                           input int exp_rwc);
    int cyc, rw, pcw, mw, ill, alu2, rwc;
    bit seen, done;
    logic irw;
    cyc = 0; rw = 0; pcw = 0; mw = 0; ill = 0; alu2 = -1; rwc = -1;
    seen = 1'b0; done = 1'b0;
    Instr = ins;
    ALUFlags = af;
    while (!done && cyc < 24) begin
      MemReady = (cyc < 16) ? !stall[cyc] : 1'b1;
      #1;
      irw = use_b ? irw_b : irw_a;
      if (cyc == 2) alu2 = use_b ? int'(alu_b) : int'(alu_a);
      if (irw && seen) begin
        done = 1'b1;
      end else begin
        if (irw) seen = 1'b1;
        if (use_b ? rw_b : rw_a) begin rw++; if (rwc < 0) rwc = cyc; end
        if (use_b ? pcw_b : pcw_a) pcw++;
        if (use_b ? mw_b : mw_a) mw++;
        if (use_b ? ill_b : ill_a) ill++;
        step();
        cyc++;
      end
    end
    chk({tag, " finished"}, 32'(done), 32'd1);
    chk({tag, " cycles"}, cyc, exp_cyc);
    chk({tag, " RegWrite count"}, rw, exp_rw);
    chk({tag, " RegWrite cycle"}, rwc, exp_rwc);
    chk({tag, " PCWrite count"}, pcw, exp_pcw);
    chk({tag, " MemWrite count"}, mw, exp_mw);
    chk({tag, " Illegal count"}, ill, exp_ill);
    chk({tag, " ALUControl c2"}, alu2, exp_alu2);
    MemReady = 1'b1;
  endtask

  initial begin
    // reset: FETCH strobes forced low while rst_n=0
    rst_n = 1'b0; MemReady = 1'b1;
    step(); step();
    chk("rst IRWrite", irw_a, 1'b0);
    chk("rst PCWrite", pcw_a, 1'b0);
    chk("rst Illegal", ill_a, 1'b0);
    chk("rst Flags", fl_a, 4'b0000);
    chk("rst ALUSrcB", sb_a, 2'b10);
    rst_n = 1'b1;

    //         tag        b  instr         af     stall    cyc rw pcw mw il alu rwc
    run_instr("ADDS",    0, 32'hE0921003, 4'h6, 16'h0000, 4, 1, 1, 0, 0, 0, 3);
    chk("ADDS Flags", fl_a, 4'b0110);
    run_instr("CMP",     0, 32'hE1520003, 4'h3, 16'h0000, 3, 0, 1, 0, 0, 1, -1);
    chk("CMP Flags", fl_a, 4'b0011);
    run_instr("ANDS",    0, 32'hE0121003, 4'hB, 16'h0000, 4, 1, 1, 0, 0, 2, 3);
    chk("ANDS Flags", fl_a, 4'b1011);
    run_instr("ORRS",    0, 32'hE1921003, 4'h4, 16'h0000, 4, 1, 1, 0, 0, 3, 3);
    chk("ORRS Flags", fl_a, 4'b0111);
    run_instr("BEQ tkn", 0, 32'h0A000004, 4'h0, 16'h0000, 3, 0, 2, 0, 0, 0, -1);
    run_instr("CMP0",    0, 32'hE1520003, 4'h0, 16'h0000, 3, 0, 1, 0, 0, 1, -1);
    chk("CMP0 Flags", fl_a, 4'b0000);
    run_instr("BEQ nt",  0, 32'h0A000004, 4'hF, 16'h0000, 2, 0, 1, 0, 0, 0, -1);
    run_instr("ADDSEQ",  0, 32'h00921003, 4'hF, 16'h0000, 2, 0, 1, 0, 0, 0, -1);
    chk("ADDSEQ Flags", fl_a, 4'b0000);
    run_instr("CMN",     0, 32'hE1720003, 4'h9, 16'h0000, 3, 0, 1, 0, 0, 0, -1);
    chk("CMN Flags", fl_a, 4'b1001);
    run_instr("LDR stl", 0, 32'hE5921004, 4'h0, 16'h0018, 7, 1, 1, 0, 0, 0, 6);
    run_instr("LDR pc",  0, 32'hE592F004, 4'h0, 16'h0000, 5, 1, 2, 0, 0, 0, 4);
    run_instr("LDR sub", 0, 32'hE5121004, 4'h0, 16'h0000, 5, 1, 1, 0, 0, 1, 4);
    run_instr("STR stl", 0, 32'hE5821004, 4'h0, 16'h0008, 5, 0, 1, 2, 0, 0, -1);
    run_instr("MOV",     0, 32'hE1A01003, 4'h0, 16'h0000, 4, 1, 1, 0, 0, 5, 3);
    run_instr("ADD fst", 0, 32'hE0821003, 4'h0, 16'h0001, 5, 1, 1, 0, 0, 0, 4);
    run_instr("EOR",     0, 32'hE0221003, 4'h0, 16'h0000, 4, 1, 1, 0, 0, 4, 3);
    run_instr("OP11",    0, 32'hEC000000, 4'h0, 16'h0000, 2, 0, 1, 0, 1, 0, -1);
    run_instr("NV",      0, 32'hF0921003, 4'h0, 16'h0000, 2, 0, 1, 0, 1, 0, -1);
    run_instr("RSB",     0, 32'hE0621003, 4'h0, 16'h0000, 2, 0, 1, 0, 1, 0, -1);
    chk("CMN Flags kept", fl_a, 4'b1001);

    // reset asserted while a store is waiting in MEMWR
    rst_n = 1'b0; step(); rst_n = 1'b1;
    chk("rst2 Flags", fl_a, 4'b0000);
    Instr = 32'hE5821004; MemReady = 1'b1;
    step(); step(); step();
    MemReady = 1'b0; #1;
    chk("MEMWR MemWrite", mw_a, 1'b1);
    chk("MEMWR AdrSrc", adr_a, 1'b1);
    rst_n = 1'b0; #1;
    chk("MEMWR rst MemWrite", mw_a, 1'b0);
    step();
    rst_n = 1'b1; MemReady = 1'b0; #1;
    chk("post rst MemWrite", mw_a, 1'b0);
    chk("post rst AdrSrc", adr_a, 1'b0);
    chk("post rst ALUSrcB", sb_a, 2'b10);
    chk("post rst IRWrite", irw_a, 1'b0);
    MemReady = 1'b1;

    // two-bit ALUControl build; b is also in FETCH after the reset above
    run_instr("b EOR",   1, 32'hE0221003, 4'h0, 16'h0000, 2, 0, 1, 0, 1, 0, -1);
    run_instr("b ADDS",  1, 32'hE0921003, 4'h6, 16'h0000, 4, 1, 1, 0, 0, 0, 3);
    chk("b ADDS Flags", fl_b, 4'b0110);
    run_instr("b SUB",   1, 32'hE0421003, 4'h0, 16'h0000, 4, 1, 1, 0, 0, 1, 3);
    run_instr("b MOV",   1, 32'hE1A01003, 4'h0, 16'h0000, 2, 0, 1, 0, 1, 0, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
